// File: rtl/fuel_pump_lock.sv
// rtl/fuel_pump_lock.sv - anti-theft fuel pump interlock with secret switch code and timed lockout
module fuel_pump_lock #(
    parameter int                NUM_SW         = 4,
    parameter logic [NUM_SW-1:0] CODE           = 4'b1010,
    parameter int                MAX_TRIES      = 3,
    parameter int                ARM_TIMEOUT    = 1000,
    parameter int                LOCKOUT_CYCLES = 5000,
    localparam int               TRY_W          = $clog2(MAX_TRIES + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ignition,
    input  logic              brake,
    input  logic [NUM_SW-1:0] hidden_sw,
    output logic              fuel_pump,
    output logic              locked_out,
    output logic              alarm,
    output logic [TRY_W-1:0]  fail_count,
    output logic [1:0]        state
);

    localparam int CNT_MAX = (ARM_TIMEOUT > LOCKOUT_CYCLES) ? ARM_TIMEOUT : LOCKOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] ARM_LAST  = CNT_W'(ARM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAIT = 2'd1,
        S_RUN  = 2'd2,
        S_LOCK = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_next;
    logic [TRY_W-1:0] fail_q;
    logic [TRY_W-1:0] fail_next;
    logic [TRY_W-1:0] fail_inc;
    logic [CNT_W-1:0] cnt_q;
    logic             brake_d;
    logic             alarm_q;
    logic             attempt;
    logic             code_ok;

    // brake_d resets high so a pedal already held down never counts as a press
    assign attempt  = brake & ~brake_d;
    assign code_ok  = (hidden_sw == CODE);
    assign fail_inc = fail_q + TRY_W'(1);

    always_comb begin
        state_next = state_q;
        fail_next  = fail_q;
        case (state_q)
            S_OFF: begin
                if (ignition) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ignition) begin
                    state_next = S_OFF;
                end else if (attempt && code_ok) begin
                    state_next = S_RUN;
                    fail_next  = '0;
                end else begin
                    if (attempt) begin
                        fail_next = fail_inc;
                        if (fail_inc == TRY_LIMIT) begin
                            state_next = S_LOCK;
                        end
                    end
                    // window expiry only loses to a correct press
                    if (cnt_q == ARM_LAST) begin
                        state_next = S_LOCK;
                    end
                end
            end
            S_RUN: begin
                if (!ignition) begin
                    state_next = S_OFF;
                end
            end
            S_LOCK: begin
                if (cnt_q == LOCK_LAST) begin
                    state_next = S_OFF;
                    fail_next  = '0;
                end
            end
            default: begin
                state_next = S_OFF;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_OFF;
            fail_q  <= '0;
            cnt_q   <= '0;
            brake_d <= 1'b1;
            alarm_q <= 1'b0;
        end else begin
            state_q <= state_next;
            fail_q  <= fail_next;
            brake_d <= brake;
            alarm_q <= (state_next == S_LOCK) && (state_q != S_LOCK);
            // one counter serves both the auth window and the lockout timer
            if (state_next != state_q) begin
                cnt_q <= '0;
            end else if ((state_q == S_WAIT) || (state_q == S_LOCK)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign fuel_pump  = (state_q == S_RUN);
    assign locked_out = (state_q == S_LOCK);
    assign alarm      = alarm_q;
    assign fail_count = fail_q;
    assign state      = state_q;

endmodule

// File: tb/tb_fuel_pump_lock.sv
// tb/tb_fuel_pump_lock.sv - scoreboard bench for fuel_pump_lock against a time-stamp reference model
module tb_fuel_pump_lock;

    localparam int         NUM_SW   = 4;
    localparam logic [3:0] CODE     = 4'b1010;
    localparam int         MAX      = 3;
    localparam int         ARM      = 20;
    localparam int         LOCK     = 10;
    localparam logic [3:0] WRONG    = 4'b0110;

    logic       clock;
    logic       reset;
    logic       ignition;
    logic       brake;
    logic [3:0] hidden_sw;
    logic       fuel_pump;
    logic       locked_out;
    logic       alarm;
    logic [1:0] fail_count;
    logic [1:0] state;

    fuel_pump_lock #(
        .NUM_SW(NUM_SW),
        .CODE(CODE),
        .MAX_TRIES(MAX),
        .ARM_TIMEOUT(ARM),
        .LOCKOUT_CYCLES(LOCK)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ignition(ignition),
        .brake(brake),
        .hidden_sw(hidden_sw),
        .fuel_pump(fuel_pump),
        .locked_out(locked_out),
        .alarm(alarm),
        .fail_count(fail_count),
        .state(state)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        int st;
        int fp;
        int lo;
        int al;
        int fc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // model: mode plus edge timestamps of WAIT_AUTH / LOCKOUT entry
    int m_cyc        = 0;
    int m_mode       = 0;
    int m_wait_start = 0;
    int m_lock_start = 0;
    int m_fails      = 0;
    bit m_prev       = 1'b1;
    bit m_alarm      = 1'b0;

    task automatic model_edge(input bit r, input bit i, input bit b, input logic [3:0] s);
        bit   attempt;
        bit   lock_now;
        exp_t e;
        m_cyc++;
        if (r) begin
            m_mode  = 0;
            m_fails = 0;
            m_prev  = 1'b1;
            m_alarm = 1'b0;
        end else begin
            attempt  = b && !m_prev;
            m_prev   = b;
            m_alarm  = 1'b0;
            lock_now = 1'b0;
            case (m_mode)
                0: if (i) begin
                    m_mode       = 1;
                    m_wait_start = m_cyc;
                end
                1: begin
                    if (!i) begin
                        m_mode = 0;
                    end else if (attempt && s == CODE) begin
                        m_mode  = 2;
                        m_fails = 0;
                    end else begin
                        if (attempt) begin
                            m_fails++;
                            if (m_fails == MAX) lock_now = 1'b1;
                        end
                        if (m_cyc - m_wait_start == ARM) lock_now = 1'b1;
                        if (lock_now) begin
                            m_mode       = 3;
                            m_lock_start = m_cyc;
                            m_alarm      = 1'b1;
                        end
                    end
                end
                2: if (!i) m_mode = 0;
                default: if (m_cyc - m_lock_start == LOCK) begin
                    m_mode  = 0;
                    m_fails = 0;
                end
            endcase
        end
        e.st = m_mode;
        e.fp = (m_mode == 2) ? 1 : 0;
        e.lo = (m_mode == 3) ? 1 : 0;
        e.al = m_alarm ? 1 : 0;
        e.fc = m_fails;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit r, input bit i, input bit b, input logic [3:0] s);
        @(negedge clock);
        reset     = r;
        ignition  = i;
        brake     = b;
        hidden_sw = s;
        @(posedge clock);
        model_edge(r, i, b, s);
    endtask

    task automatic press(input logic [3:0] s);
        step(1'b0, 1'b1, 1'b0, s);
        step(1'b0, 1'b1, 1'b1, s);
    endtask

    task automatic idle(input int n, input bit i);
        for (int k = 0; k < n; k++) step(1'b0, i, 1'b0, CODE);
    endtask

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0d, expected %0d", name, m_cyc, act, req);
        end
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("state", int'(state), e.st);
            chk("fuel_pump", int'(fuel_pump), e.fp);
            chk("locked_out", int'(locked_out), e.lo);
            chk("alarm", int'(alarm), e.al);
            chk("fail_count", int'(fail_count), e.fc);
        end
    end

    initial begin
        bit         ri;
        bit         rb;
        logic [3:0] rs;
        reset     = 1'b1;
        ignition  = 1'b0;
        brake     = 1'b0;
        hidden_sw = 4'd0;

        // correct code, then key off
        step(1'b1, 1'b0, 1'b0, CODE);
        step(1'b1, 1'b0, 1'b0, CODE);
        idle(4, 1'b1);
        step(1'b0, 1'b1, 1'b1, CODE);
        step(1'b0, 1'b1, 1'b1, CODE);
        idle(2, 1'b0);

        // three wrong codes into lockout and back out
        step(1'b1, 1'b0, 1'b0, CODE);
        idle(1, 1'b1);
        for (int k = 0; k < 3; k++) press(WRONG);
        idle(15, 1'b1);

        // key cycling keeps the try count
        step(1'b1, 1'b0, 1'b0, CODE);
        idle(1, 1'b1);
        press(WRONG);
        press(WRONG);
        idle(2, 1'b0);
        idle(1, 1'b1);
        press(WRONG);
        idle(12, 1'b1);

        // window timeout, then success on the last window cycle
        step(1'b1, 1'b0, 1'b0, CODE);
        idle(25, 1'b1);
        step(1'b1, 1'b0, 1'b0, CODE);
        idle(20, 1'b1);
        step(1'b0, 1'b1, 1'b1, CODE);
        idle(2, 1'b0);

        // brake held through reset and key-on is not an attempt
        step(1'b1, 1'b0, 1'b1, CODE);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1, CODE);
        press(CODE);
        idle(2, 1'b0);

        // reset in mid-lockout, then key drop racing a press
        step(1'b1, 1'b0, 1'b0, CODE);
        idle(1, 1'b1);
        for (int k = 0; k < 3; k++) press(WRONG);
        idle(3, 1'b1);
        step(1'b1, 1'b1, 1'b0, CODE);
        idle(1, 1'b1);
        press(WRONG);
        step(1'b0, 1'b1, 1'b0, WRONG);
        step(1'b0, 1'b0, 1'b1, WRONG);
        idle(2, 1'b0);

        // randomized traffic
        ri = 1'b1;
        rb = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 39) == 0) ri = ~ri;
            if ($urandom_range(0, 2) == 0) rb = ~rb;
            rs = ($urandom_range(0, 3) == 0) ? CODE : 4'($urandom);
            step(($urandom_range(0, 499) == 0), ri, rb, rs);
        end

        @(negedge clock);
        @(negedge clock);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
